// File: rtl/seqdet_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
// The optional per-bit compare mask is enabled with the SEQDET_MASK_EN macro.
package seqdet_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } fill_state_t;

    localparam int DEF_W = 3;
    localparam logic [DEF_W-1:0] DEF_PAT = 3'b110;
    localparam int DEF_CNT_W = 8;

    // Fill counter must be able to hold the value W itself.
    function automatic int fill_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seqdet_shreg.sv
// W-bit serial history register: shifts in at bit 0 when enabled.
// Synchronous clear takes priority over the shift.
module seqdet_shreg #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         din,
    output logic [W-1:0] q
);

    logic [W-1:0] shift_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            shift_reg <= '0;
        end else if (en) begin
            shift_reg <= {shift_reg[W-2:0], din};
        end
    end

    assign q = shift_reg;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime pattern, overlap control and saturating
// match counter. Define SEQDET_MASK_EN to add a per-bit don't-care mask (cfg_mask).
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int             W           = DEF_W,
    parameter logic [W-1:0]   DEF_PATTERN = DEF_PAT,
    parameter int             CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             str_in,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [W-1:0]     cfg_pattern,
`ifdef SEQDET_MASK_EN
    input  logic [W-1:0]     cfg_mask,
`endif
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic [W-1:0]     str_out,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int FW = fill_w(W);
    localparam logic [FW-1:0] FULL = FW'(W);

    logic [W-1:0]     hist;
    logic [W-1:0]     hist_next;
    logic [W-1:0]     pattern_reg;
    logic [W-1:0]     mask;
    logic [W-1:0]     miss;
    logic [FW-1:0]    fill_reg, fill_next, fill_inc;
    fill_state_t      state_reg, state_next;
    logic             match_reg, match_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             accept;
    logic             hit;

    // A configuration load wins over data: the bit offered that cycle is dropped.
    assign accept    = in_valid && !cfg_load;
    assign hist_next = {hist[W-2:0], str_in};

    seqdet_shreg #(.W(W)) u_shreg (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .clr (cfg_load),
        .din (str_in),
        .q   (hist)
    );

`ifdef SEQDET_MASK_EN
    logic [W-1:0] mask_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_reg <= '1;
        end else if (cfg_load) begin
            mask_reg <= cfg_mask;
        end
    end

    assign mask = mask_reg;
`else
    assign mask = '1;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_cmp
            assign miss[gi] = mask[gi] & (hist_next[gi] ^ pattern_reg[gi]);
        end
    endgenerate

    always_comb begin
        fill_inc   = (fill_reg == FULL) ? FULL : fill_reg + 1'b1;
        hit        = accept && (fill_inc == FULL) && (miss == '0);
        fill_next  = fill_reg;
        match_next = 1'b0;
        cnt_next   = cnt_reg;

        if (cfg_load) begin
            fill_next = '0;
        end else if (accept) begin
            match_next = hit;
            // Non-overlap mode demands W fresh bits after every match.
            fill_next  = (hit && !cfg_overlap) ? '0 : fill_inc;
        end

        state_next = (fill_next == FULL) ? ARMED : FILL;

        if (cnt_clr) begin
            cnt_next = '0;
        end else if (hit && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= FILL;
            fill_reg    <= '0;
            match_reg   <= 1'b0;
            cnt_reg     <= '0;
            pattern_reg <= DEF_PATTERN;
        end else begin
            state_reg <= state_next;
            fill_reg  <= fill_next;
            match_reg <= match_next;
            cnt_reg   <= cnt_next;
            if (cfg_load) begin
                pattern_reg <= cfg_pattern;
            end
        end
    end

    assign str_out   = hist;
    assign match     = match_reg;
    assign match_cnt = cnt_reg;
    assign armed     = (state_reg == ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios plus a randomized
// run against a bit-count based reference model. Mask scenario needs SEQDET_MASK_EN.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst;

    // Instance A: W=3, pattern 110, 8-bit counter
    logic       a_in, a_valid, a_load, a_ov, a_clr;
    logic [2:0] a_pat, a_mask;
    logic [2:0] a_out;
    logic       a_match, a_armed;
    logic [7:0] a_cnt;

    // Instance B: W=2, pattern 11, 2-bit counter
    logic       b_in, b_valid, b_load, b_ov, b_clr;
    logic [1:0] b_pat, b_mask;
    logic [1:0] b_out;
    logic       b_match, b_armed;
    logic [1:0] b_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state for instance A
    int m_hist, m_since, m_pat, m_match, m_cnt;

    always #5 clk = ~clk;

    seq_detector_param #(.W(3), .DEF_PATTERN(3'b110), .CNT_W(8)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .str_in      (a_in),
        .in_valid    (a_valid),
        .cfg_load    (a_load),
        .cfg_pattern (a_pat),
`ifdef SEQDET_MASK_EN
        .cfg_mask    (a_mask),
`endif
        .cfg_overlap (a_ov),
        .cnt_clr     (a_clr),
        .str_out     (a_out),
        .match       (a_match),
        .match_cnt   (a_cnt),
        .armed       (a_armed)
    );

    seq_detector_param #(.W(2), .DEF_PATTERN(2'b11), .CNT_W(2)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .str_in      (b_in),
        .in_valid    (b_valid),
        .cfg_load    (b_load),
        .cfg_pattern (b_pat),
`ifdef SEQDET_MASK_EN
        .cfg_mask    (b_mask),
`endif
        .cfg_overlap (b_ov),
        .cnt_clr     (b_clr),
        .str_out     (b_out),
        .match       (b_match),
        .match_cnt   (b_cnt),
        .armed       (b_armed)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic b);
        a_valid = v;
        a_in    = b;
        cyc();
        $display("txn A valid=%b bit=%b -> str_out=%b match=%b cnt=%0d armed=%b",
                 v, b, a_out, a_match, a_cnt, a_armed);
    endtask

    task automatic load_a(input logic [2:0] pat, input logic [2:0] msk, input logic clr);
        a_pat   = pat;
        a_mask  = msk;
        a_load  = 1'b1;
        a_clr   = clr;
        a_valid = 1'b1;
        a_in    = 1'b1;
        cyc();
        a_load  = 1'b0;
        a_clr   = 1'b0;
        a_valid = 1'b0;
        $display("txn A load pattern=%b mask=%b clr=%b -> str_out=%b cnt=%0d",
                 pat, msk, clr, a_out, a_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in = 0; a_valid = 0; a_load = 0; a_ov = 1; a_clr = 0; a_pat = 0; a_mask = 3'b111;
        b_in = 0; b_valid = 0; b_load = 0; b_ov = 1; b_clr = 0; b_pat = 0; b_mask = 2'b11;
        cyc();
        cyc();
        rst = 1'b0;
        $display("txn reset released");
        checks++;
        if (a_out !== 3'b000) begin errors++; $display("FAIL reset_a_str_out got %b want 000", a_out); end
        checks++;
        if (a_match !== 1'b0 || a_armed !== 1'b0) begin
            errors++; $display("FAIL reset_a_flags got match=%b armed=%b want 0 0", a_match, a_armed);
        end
        checks++;
        if (a_cnt !== 8'd0) begin errors++; $display("FAIL reset_a_cnt got %0d want 0", a_cnt); end
        checks++;
        if (b_out !== 2'b00 || b_cnt !== 2'd0 || b_armed !== 1'b0 || b_match !== 1'b0) begin
            errors++; $display("FAIL reset_b got out=%b cnt=%0d armed=%b match=%b want all 0",
                               b_out, b_cnt, b_armed, b_match);
        end
    endtask

    task automatic test_basic_match();
        a_ov = 1'b1;
        drive_a(1, 1);
        checks++;
        if (a_match !== 1'b0) begin errors++; $display("FAIL basic_bit1 got match=%b want 0", a_match); end
        drive_a(1, 1);
        checks++;
        if (a_match !== 1'b0 || a_armed !== 1'b0) begin
            errors++; $display("FAIL basic_bit2 got match=%b armed=%b want 0 0", a_match, a_armed);
        end
        drive_a(1, 0);
        checks++;
        if (a_match !== 1'b1 || a_cnt !== 8'd1 || a_out !== 3'b110 || a_armed !== 1'b1) begin
            errors++; $display("FAIL basic_bit3 got match=%b cnt=%0d out=%b armed=%b want 1 1 110 1",
                               a_match, a_cnt, a_out, a_armed);
        end
        drive_a(0, 0);
        checks++;
        if (a_match !== 1'b0 || a_cnt !== 8'd1) begin
            errors++; $display("FAIL basic_after got match=%b cnt=%0d want 0 1", a_match, a_cnt);
        end
    endtask

    task automatic test_valid_gap();
        int nm;
        nm = 0;
        load_a(3'b110, 3'b111, 1'b0);
        checks++;
        if (a_out !== 3'b000 || a_armed !== 1'b0 || a_cnt !== 8'd1) begin
            errors++; $display("FAIL load_clears got out=%b armed=%b cnt=%0d want 000 0 1",
                               a_out, a_armed, a_cnt);
        end
        drive_a(1, 1); nm += a_match;
        drive_a(1, 1); nm += a_match;
        drive_a(0, 0);
        checks++;
        if (a_match !== 1'b0 || a_out !== 3'b011) begin
            errors++; $display("FAIL gap_hold got match=%b out=%b want 0 011", a_match, a_out);
        end
        drive_a(1, 1); nm += a_match;
        drive_a(1, 0);
        checks++;
        if (a_match !== 1'b1) begin errors++; $display("FAIL gap_final got match=%b want 1", a_match); end
        nm += a_match;
        checks++;
        if (nm != 1 || a_cnt !== 8'd2) begin
            errors++; $display("FAIL gap_count got matches=%0d cnt=%0d want 1 2", nm, a_cnt);
        end
    endtask

    task automatic test_overlap();
        logic [4:0] seen;
        logic [4:0] stream;
        stream = 5'b10101;
        for (int pass = 0; pass < 2; pass++) begin
            a_ov = (pass == 0);
            load_a(3'b101, 3'b111, 1'b1);
            checks++;
            if (a_cnt !== 8'd0) begin errors++; $display("FAIL ovl_clr_on_load got cnt=%0d want 0", a_cnt); end
            for (int i = 0; i < 5; i++) begin
                drive_a(1, stream[4-i]);
                seen[4-i] = a_match;
                if (i == 2 && pass == 1) begin
                    checks++;
                    if (a_armed !== 1'b0) begin
                        errors++; $display("FAIL novl_rearm got armed=%b want 0", a_armed);
                    end
                end
            end
            checks++;
            if (pass == 0 && (seen !== 5'b00101 || a_cnt !== 8'd2)) begin
                errors++; $display("FAIL overlap got matches=%b cnt=%0d want 00101 2", seen, a_cnt);
            end else if (pass == 1 && (seen !== 5'b00100 || a_cnt !== 8'd1)) begin
                errors++; $display("FAIL nonoverlap got matches=%b cnt=%0d want 00100 1", seen, a_cnt);
            end
        end
        a_ov = 1'b1;
    endtask

    task automatic test_saturate();
        int nm;
        nm = 0;
        b_ov = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b_valid = 1'b1; b_in = 1'b1;
            cyc();
            $display("txn B bit=1 -> match=%b cnt=%0d", b_match, b_cnt);
            nm += b_match;
            if (i == 2) begin
                checks++;
                if (b_cnt !== 2'd2) begin errors++; $display("FAIL sat_progress got cnt=%0d want 2", b_cnt); end
            end
        end
        checks++;
        if (nm != 9 || b_cnt !== 2'd3 || b_out !== 2'b11) begin
            errors++; $display("FAIL sat_run got matches=%0d cnt=%0d out=%b want 9 3 11", nm, b_cnt, b_out);
        end
        b_clr = 1'b1;
        cyc();
        $display("txn B bit=1 clr=1 -> match=%b cnt=%0d", b_match, b_cnt);
        checks++;
        if (b_match !== 1'b1 || b_cnt !== 2'd0) begin
            errors++; $display("FAIL clr_wins got match=%b cnt=%0d want 1 0", b_match, b_cnt);
        end
        b_clr = 1'b0;
        cyc();
        $display("txn B bit=1 -> match=%b cnt=%0d", b_match, b_cnt);
        b_valid = 1'b0;
        checks++;
        if (b_cnt !== 2'd1) begin errors++; $display("FAIL clr_resume got cnt=%0d want 1", b_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] seen;
        logic [3:0] stream;
        stream = 4'b0110;
        load_a(3'b011, 3'b111, 1'b0);
        drive_a(1, 1);
        drive_a(1, 1);
        rst = 1'b1;
        a_valid = 1'b1;
        cyc();
        rst = 1'b0;
        a_valid = 1'b0;
        $display("txn A reset mid-pattern");
        checks++;
        if (a_out !== 3'b000 || a_match !== 1'b0 || a_cnt !== 8'd0 || a_armed !== 1'b0) begin
            errors++; $display("FAIL midrst got out=%b match=%b cnt=%0d armed=%b want 000 0 0 0",
                               a_out, a_match, a_cnt, a_armed);
        end
        for (int i = 0; i < 4; i++) begin
            drive_a(1, stream[3-i]);
            seen[3-i] = a_match;
        end
        checks++;
        if (seen !== 4'b0001 || a_cnt !== 8'd1) begin
            errors++; $display("FAIL midrst_pattern got matches=%b cnt=%0d want 0001 1", seen, a_cnt);
        end
    endtask

`ifdef SEQDET_MASK_EN
    task automatic test_mask();
        logic [8:0] stream;
        logic [2:0] seen;
        stream = 9'b110_100_010;
        a_ov = 1'b0;
        load_a(3'b100, 3'b101, 1'b1);
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 3; i++) drive_a(1, stream[8 - 3*g - i]);
            seen[2-g] = a_match;
        end
        checks++;
        if (seen !== 3'b110) begin errors++; $display("FAIL mask_groups got %b want 110", seen); end
        load_a(3'b110, 3'b111, 1'b1);
        a_ov = 1'b1;
    endtask
`endif

    task automatic test_random();
        int hit;
        rst = 1'b1; a_load = 0; a_clr = 0; a_valid = 0; a_mask = 3'b111;
        cyc();
        rst = 1'b0;
        m_hist = 0; m_since = 0; m_pat = 3'b110; m_match = 0; m_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            a_valid = ($urandom % 4) != 0;
            a_in    = $urandom % 2;
            a_load  = ($urandom % 40) == 0;
            a_pat   = $urandom % 8;
            a_clr   = ($urandom % 30) == 0;
            if (n % 50 == 0) a_ov = $urandom % 2;
            hit = 0;
            if (a_load) begin
                m_pat = a_pat; m_since = 0; m_hist = 0; m_match = 0;
            end else if (a_valid) begin
                m_hist  = ((m_hist << 1) | a_in) & 7;
                m_since = m_since + 1;
                hit     = (m_since >= 3) && (m_hist == m_pat);
                m_match = hit;
                if (hit && !a_ov) m_since = 0;
            end else begin
                m_match = 0;
            end
            if (a_clr) m_cnt = 0;
            else if (hit) m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
            cyc();
            $display("txn rnd %0d v=%b b=%b ld=%b pat=%b ov=%b clr=%b -> out=%b m=%b cnt=%0d arm=%b",
                     n, a_valid, a_in, a_load, a_pat, a_ov, a_clr, a_out, a_match, a_cnt, a_armed);
            checks++;
            if (a_out !== 3'(m_hist) || a_match !== 1'(m_match) || a_cnt !== 8'(m_cnt)
                || a_armed !== (m_since >= 3)) begin
                errors++;
                $display("FAIL rnd_%0d got out=%b match=%b cnt=%0d armed=%b want %b %0d %0d %0d",
                         n, a_out, a_match, a_cnt, a_armed, 3'(m_hist), m_match, m_cnt, m_since >= 3);
            end
        end
        a_load = 0; a_clr = 0; a_valid = 0;
    endtask

    initial begin
        test_reset();
        test_basic_match();
        test_valid_gap();
        test_overlap();
        test_saturate();
        test_reset_mid();
`ifdef SEQDET_MASK_EN
        test_mask();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
